ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-port arbiter in front of the single-port 64KB Ram (async read, sync write).
//  Shares it between the video tile/pattern fetcher (read-only, high priority) and
//  the CPU bus (read/write). Sits between both requesters and the Ram instance.
//  A starvation guard gives the CPU a slot after a bounded run of video grants.
// PARAMETERS
//  Bits         16  address width; must match the Ram Bits parameter
//  StarveLimit  4   consecutive video grants while CPU waits before the CPU is forced in (>=1)
// PORTS
//  clk        in   1     system clock; all state on rising edge
//  reset      in   1     asynchronous, active-high reset
//  vid_req    in   1     video read request; held with vid_addr stable until vid_ack
//  vid_addr   in   Bits  video read address
//  vid_ack    out  1     one-cycle pulse; vid_data valid in the same cycle
//  vid_data   out  8     registered video read data; holds until the next vid_ack
//  cpu_req    in   1     CPU request; held with cpu_we/addr/wdata stable until cpu_ack
//  cpu_we     in   1     1 = write, 0 = read
//  cpu_addr   in   Bits  CPU address
//  cpu_wdata  in   8     CPU write data
//  cpu_ack    out  1     one-cycle pulse; on reads cpu_rdata valid in the same cycle
//  cpu_rdata  out  8     registered CPU read data; holds until the next CPU read ack
//  ram_we     out  1     to Ram writeEnabled
//  ram_addr   out  Bits  to Ram address
//  ram_wdata  out  8     to Ram dataIn
//  ram_rdata  in   8     from Ram dataOut (combinational w.r.t. ram_addr)
// BEHAVIOUR
//  - Reset (async): state IDLE; vid_ack=cpu_ack=0, ram_we=0 immediately;
//    vid_data=cpu_rdata=0; ram_addr=0; ram_wdata=0; streak counter=0.
//  - States: IDLE, GNT_VID, GNT_CPU, ACK_VID, ACK_CPU.
//  - Arbitration happens at the edge leaving IDLE, ACK_VID or ACK_CPU:
//    cpu_req && (!vid_req || streak==StarveLimit) -> GNT_CPU; else vid_req -> GNT_VID;
//    else IDLE. The winner's address/we/wdata are captured into ram_* registers.
//  - GNT_x (1 cycle): ram_addr/ram_wdata driven from the captured registers; ram_we=1
//    only in GNT_CPU with captured we=1; Ram write occurs on the edge ending GNT_CPU.
//    At that edge ram_rdata is latched into vid_data (GNT_VID) or cpu_rdata (GNT_CPU
//    read only; cpu_rdata unchanged on writes). Next state ACK_x.
//  - ACK_x (1 cycle): x_ack=1, ram_we=0, ram_addr holds. Requester drops req or
//    presents a new request before the next edge; that edge re-arbitrates.
//  - Latency: req high before edge E0 (state IDLE) -> GNT at E0 -> ack high E1..E2.
//    Throughput: one access per 2 cycles, back-to-back with no IDLE between.
//  - Streak counter: +1 on each GNT_VID entry while cpu_req=1 (saturates at
//    StarveLimit); cleared on GNT_CPU entry or at any edge where cpu_req=0.
//  - Simultaneous req with streak<StarveLimit: video wins; CPU is served next, provided
//    video does not re-request; with vid_req held continuously, CPU is served after
//    StarveLimit video grants.
//  - Only one ack pulse per granted request; never both acks in the same cycle.
//  - Reset mid-access: access abandoned, no ack, pending write suppressed (ram_we low
//    before the edge); requesters re-issue after reset.
//  - Address and data passed unmodified, no width change; Bits-wide addresses do not wrap.
// TESTING
//  1 CPU write 0x2100<=0xA5, then read 0x2100 -> cpu_ack 1 cycle each; read cpu_rdata=0xA5.
//  2 After power-up, video read 0x2000 -> vid_ack at 2nd cycle after req, vid_data=0x0E.
//  3 vid_req+cpu_req same edge (CPU read 0x0003) -> vid_ack first, cpu_ack 2 cycles later, cpu_rdata=0x00.
//  4 vid_req held, cpu_req held, StarveLimit=4 -> exactly 4 vid_acks, then 1 cpu_ack, repeat.
//  5 reset pulsed during GNT_CPU write of 0xFF to 0x0010 -> ram_we falls at once, no cpu_ack, mem[0x10] unchanged (0x01).
//  6 CPU reads 0x2000..0x2003 back-to-back -> cpu_ack every 2nd cycle, data 0x0E,0x80,0x88,0x00.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one async-read/sync-write RAM between a high-priority video reader
// and the CPU, with a starvation guard that forces the CPU in after a bounded video run.
module ram_arbiter #(
   parameter int Bits        = 16,
   parameter int StarveLimit = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            vid_req,
   input  logic [Bits-1:0] vid_addr,
   output logic            vid_ack,
   output logic [7:0]      vid_data,
   input  logic            cpu_req,
   input  logic            cpu_we,
   input  logic [Bits-1:0] cpu_addr,
   input  logic [7:0]      cpu_wdata,
   output logic            cpu_ack,
   output logic [7:0]      cpu_rdata,
   output logic            ram_we,
   output logic [Bits-1:0] ram_addr,
   output logic [7:0]      ram_wdata,
   input  logic [7:0]      ram_rdata
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] GNT_VID = 3'd1;
   localparam logic [2:0] GNT_CPU = 3'd2;
   localparam logic [2:0] ACK_VID = 3'd3;
   localparam logic [2:0] ACK_CPU = 3'd4;
   localparam int SW = $clog2(StarveLimit + 1);
   localparam logic [SW-1:0] LIMIT = SW'(StarveLimit);

   logic [2:0]      state_q, state_d;
   logic [SW-1:0]   streak_q, streak_d;
   logic [Bits-1:0] addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d, vid_data_q, vid_data_d, cpu_rdata_q, cpu_rdata_d;
   logic            we_q, we_d;
   logic            arb, pick_cpu, pick_vid;

   always_comb begin
      arb         = state_q != GNT_VID && state_q != GNT_CPU;
      pick_cpu    = arb && cpu_req && (!vid_req || streak_q == LIMIT);
      pick_vid    = arb && !pick_cpu && vid_req;
      state_d     = pick_cpu ? GNT_CPU : pick_vid ? GNT_VID : arb ? IDLE :
                    state_q == GNT_VID ? ACK_VID : ACK_CPU;
      addr_d      = pick_cpu ? cpu_addr : pick_vid ? vid_addr : addr_q;
      we_d        = pick_cpu ? cpu_we : pick_vid ? 1'b0 : we_q;
      wdata_d     = pick_cpu ? cpu_wdata : wdata_q;
      // the streak only measures how long a waiting CPU has been passed over
      streak_d    = (!cpu_req || pick_cpu) ? '0 :
                    (pick_vid && streak_q < LIMIT) ? streak_q + SW'(1) : streak_q;
      vid_data_d  = state_q == GNT_VID ? ram_rdata : vid_data_q;
      cpu_rdata_d = (state_q == GNT_CPU && !we_q) ? ram_rdata : cpu_rdata_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         streak_q    <= '0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         vid_data_q  <= '0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         vid_data_q  <= vid_data_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign vid_ack   = state_q == ACK_VID;
   assign cpu_ack   = state_q == ACK_CPU;
   assign ram_we    = state_q == GNT_CPU && we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign vid_data  = vid_data_q;
   assign cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives ram_arbiter against a behavioural 64KB RAM and checks acks,
// latency, read data, starvation ordering and reset-abort behaviour.
module tb_ram_arbiter;
   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        vid_req = 1'b0, vid_ack;
   logic [15:0] vid_addr = '0;
   logic [7:0]  vid_data;
   logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_ack;
   logic [15:0] cpu_addr = '0;
   logic [7:0]  cpu_wdata = '0, cpu_rdata;
   logic        ram_we;
   logic [15:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;
   logic [7:0]  mem [0:65535];
   int compared = 0, mismatched = 0;

   ram_arbiter #(.Bits(16), .StarveLimit(4)) dut (
      .clk(clk), .reset(reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr];

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h2000] = 8'h0E;
      mem[16'h2001] = 8'h80;
      mem[16'h2002] = 8'h88;
      mem[16'h0010] = 8'h01;
      forever begin
         @(posedge clk);
         if (ram_we) mem[ram_addr] <= ram_wdata;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (vid_ack || cpu_ack) chk("single_ack", int'(vid_ack && cpu_ack), 0);

   initial begin
      vec_t        tbl [11];
      logic [7:0]  exp_q [$];
      bit          ack_q [$];
      logic [7:0]  last_rd;
      int          cyc, vid_cyc, cpu_cyc, acks;
      tbl[0]  = '{1'b1, 16'h2100, 8'hA5, 8'h00};
      tbl[1]  = '{1'b0, 16'h2100, 8'h00, 8'hA5};
      tbl[2]  = '{1'b0, 16'h2000, 8'h00, 8'h0E};
      tbl[3]  = '{1'b0, 16'h2001, 8'h00, 8'h80};
      tbl[4]  = '{1'b0, 16'h2002, 8'h00, 8'h88};
      tbl[5]  = '{1'b0, 16'h2003, 8'h00, 8'h00};
      tbl[6]  = '{1'b1, 16'hFFFF, 8'h5A, 8'h00};
      tbl[7]  = '{1'b0, 16'hFFFF, 8'h00, 8'h5A};
      tbl[8]  = '{1'b1, 16'h0000, 8'hC3, 8'h00};
      tbl[9]  = '{1'b0, 16'h0000, 8'h00, 8'hC3};
      tbl[10] = '{1'b0, 16'h2100, 8'h00, 8'hA5};

      repeat (2) @(negedge clk);
      chk("rst_vid_ack", vid_ack, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_vid_data", vid_data, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      reset = 1'b0;
      @(negedge clk);

      // video read straight after power-up
      vid_addr = 16'h2000;
      vid_req  = 1'b1;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!vid_ack && cyc < 20);
      chk("vid_latency", cyc, 2);
      chk("vid_data", vid_data, 8'h0E);
      vid_req = 1'b0;
      @(negedge clk);
      chk("vid_ack_pulse", vid_ack, 0);
      chk("vid_data_hold", vid_data, 8'h0E);

      // back-to-back CPU accesses from the table
      last_rd = 8'h00;
      for (int i = 0; i < 11; i++) begin
         cpu_req   = 1'b1;
         cpu_we    = tbl[i].we;
         cpu_addr  = tbl[i].addr;
         cpu_wdata = tbl[i].wdata;
         exp_q.push_back(tbl[i].we ? last_rd : tbl[i].rdata);
         if (!tbl[i].we) last_rd = tbl[i].rdata;
         cyc = 0;
         do begin @(negedge clk); cyc++; end while (!cpu_ack && cyc < 20);
         chk($sformatf("cpu_latency[%0d]", i), cyc, 2);
         chk($sformatf("cpu_rdata[%0d]", i), cpu_rdata, exp_q.pop_front());
         chk($sformatf("cpu_ram_addr[%0d]", i), ram_addr, tbl[i].addr);
         if (tbl[i].we) chk($sformatf("cpu_ram_wdata[%0d]", i), ram_wdata, tbl[i].wdata);
      end
      cpu_req = 1'b0;
      @(negedge clk);
      chk("cpu_ack_pulse", cpu_ack, 0);
      chk("sb_empty", exp_q.size(), 0);

      // simultaneous requests: video first, CPU two cycles later
      vid_addr = 16'h2002;
      cpu_we   = 1'b0;
      cpu_addr = 16'h0003;
      vid_req  = 1'b1;
      cpu_req  = 1'b1;
      cyc = 0; vid_cyc = 0; cpu_cyc = 0;
      while ((vid_req || cpu_req) && cyc < 20) begin
         @(negedge clk); cyc++;
         if (vid_ack) begin vid_cyc = cyc; vid_req = 1'b0; chk("sim_vid_data", vid_data, 8'h88); end
         if (cpu_ack) begin cpu_cyc = cyc; cpu_req = 1'b0; chk("sim_cpu_rdata", cpu_rdata, 8'h00); end
      end
      chk("sim_vid_cycle", vid_cyc, 2);
      chk("sim_cpu_cycle", cpu_cyc, 4);
      vid_req = 1'b0; cpu_req = 1'b0;
      repeat (2) @(negedge clk);

      // both held: four video grants, then one CPU grant, repeating
      vid_addr = 16'h2000;
      cpu_addr = 16'h2001;
      vid_req  = 1'b1;
      cpu_req  = 1'b1;
      for (int k = 0; k < 2; k++) begin
         repeat (4) ack_q.push_back(1'b0);
         ack_q.push_back(1'b1);
      end
      cyc = 0; acks = 0;
      while (ack_q.size() > 0 && cyc < 60) begin
         @(negedge clk); cyc++;
         if (vid_ack || cpu_ack) begin
            acks++;
            chk($sformatf("starve_order[%0d]", acks), cpu_ack, ack_q.pop_front());
            if (cpu_ack) chk("starve_cpu_data", cpu_rdata, 8'h80);
            else chk("starve_vid_data", vid_data, 8'h0E);
         end
      end
      chk("starve_done", ack_q.size(), 0);
      vid_req = 1'b0; cpu_req = 1'b0;
      repeat (3) @(negedge clk);

      // reset during a CPU write grant
      cpu_we    = 1'b1;
      cpu_addr  = 16'h0010;
      cpu_wdata = 8'hFF;
      cpu_req   = 1'b1;
      @(posedge clk); #1;
      chk("abort_we_before", ram_we, 1);
      #1 reset = 1'b1;
      #1;
      chk("abort_we_after", ram_we, 0);
      chk("abort_cpu_ack", cpu_ack, 0);
      chk("abort_cpu_rdata", cpu_rdata, 0);
      cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      acks = 0;
      repeat (4) begin @(negedge clk); if (cpu_ack) acks++; end
      chk("abort_no_ack", acks, 0);
      chk("abort_mem", mem[16'h0010], 8'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
